// File: rtl/number_hit_detector_pkg.sv
// Shared definitions for the number collision logic and the number display array.
package number_hit_detector_pkg;

  localparam int unsigned NumbersDefault = 3;
  localparam int unsigned CountWDefault  = 8;

  typedef enum logic [0:0] {
    StAccum  = 1'b0,
    StReport = 1'b1
  } hit_state_e;

endpackage

// File: rtl/number_hit_detector_lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index, one-hot and any flag.
module lsb_priority_encoder
  import number_hit_detector_pkg::*;
#(
  parameter int unsigned NUMBERS = NumbersDefault,
  parameter int unsigned IDX_W   = (NUMBERS > 1) ? $clog2(NUMBERS) : 1
) (
  input  logic [NUMBERS-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUMBERS-1:0] onehot_o,
  output logic               any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + NUMBERS'(1));
  assign any_o    = |req_i;

  always_comb begin
    idx_o = '0;
    for (int i = int'(NUMBERS) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/number_hit_detector.sv
// Accumulates player/number overlaps per frame and reports each number once per round,
// one registered one-hot pulse per cycle, lowest index first.
module number_hit_detector
  import number_hit_detector_pkg::*;
#(
  parameter int unsigned NUMBERS = NumbersDefault,
  parameter int unsigned IDX_W   = (NUMBERS > 1) ? $clog2(NUMBERS) : 1,
  parameter int unsigned COUNT_W = CountWDefault
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_of_frame_i,
  input  logic               new_round_i,
  input  logic               player_dr_i,
  input  logic [NUMBERS-1:0] numbers_dr_i,
  output logic [NUMBERS-1:0] single_hit_o,
  output logic               hit_valid_o,
  output logic [IDX_W-1:0]   hit_index_o,
  output logic [COUNT_W-1:0] hit_count_o
);

  hit_state_e         state_q, state_d;
  logic [NUMBERS-1:0] acc_q, acc_d;
  logic [NUMBERS-1:0] pending_q, pending_d;
  logic [NUMBERS-1:0] consumed_q, consumed_d;
  logic [COUNT_W-1:0] hit_count_q, hit_count_d;
  logic [NUMBERS-1:0] single_hit_q, single_hit_d;
  logic               hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0]   hit_index_q, hit_index_d;

  logic [NUMBERS-1:0] ovl;
  logic [NUMBERS-1:0] merged;
  logic [IDX_W-1:0]   pend_idx;
  logic [NUMBERS-1:0] pend_onehot;
  logic               pend_any;

  // Numbers already reported or queued never feed the accumulator again.
  assign ovl    = numbers_dr_i & {NUMBERS{player_dr_i}} & ~consumed_q & ~pending_q;
  assign merged = acc_q | ovl;

  lsb_priority_encoder #(
    .NUMBERS (NUMBERS),
    .IDX_W   (IDX_W)
  ) u_pend_enc (
    .req_i    (pending_q),
    .idx_o    (pend_idx),
    .onehot_o (pend_onehot),
    .any_o    (pend_any)
  );

  always_comb begin
    acc_d        = merged;
    pending_d    = pending_q;
    consumed_d   = consumed_q;
    state_d      = state_q;
    hit_count_d  = hit_count_q;
    single_hit_d = '0;
    hit_valid_d  = 1'b0;
    hit_index_d  = '0;

    case (state_q)
      StAccum: begin
        if (start_of_frame_i) begin
          pending_d = merged;
          acc_d     = '0;
          state_d   = (|merged) ? StReport : StAccum;
        end
      end
      StReport: begin
        if (pend_any) begin
          single_hit_d = pend_onehot;
          hit_valid_d  = 1'b1;
          hit_index_d  = pend_idx;
          consumed_d   = consumed_q | pend_onehot;
          if (hit_count_q != '1) hit_count_d = hit_count_q + COUNT_W'(1);
        end
        pending_d = pending_q & ~pend_onehot;
        if (start_of_frame_i) begin
          pending_d = pending_d | merged;
          acc_d     = '0;
        end
        state_d = (|pending_d) ? StReport : StAccum;
      end
      default: state_d = StAccum;
    endcase

    // A new round wins over everything, including a report due this cycle.
    if (new_round_i) begin
      acc_d        = '0;
      pending_d    = '0;
      consumed_d   = '0;
      hit_count_d  = '0;
      state_d      = StAccum;
      single_hit_d = '0;
      hit_valid_d  = 1'b0;
      hit_index_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StAccum;
      acc_q        <= '0;
      pending_q    <= '0;
      consumed_q   <= '0;
      hit_count_q  <= '0;
      single_hit_q <= '0;
      hit_valid_q  <= 1'b0;
      hit_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      pending_q    <= pending_d;
      consumed_q   <= consumed_d;
      hit_count_q  <= hit_count_d;
      single_hit_q <= single_hit_d;
      hit_valid_q  <= hit_valid_d;
      hit_index_q  <= hit_index_d;
    end
  end

  assign single_hit_o = single_hit_q;
  assign hit_valid_o  = hit_valid_q;
  assign hit_index_o  = hit_index_q;
  assign hit_count_o  = hit_count_q;

endmodule

// File: tb/tb_number_hit_detector.sv
// Directed bench: 3-number/8-bit-count instance plus an 8-number/2-bit-count instance.
module tb_number_hit_detector;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;

  logic       sof = 1'b0, nr = 1'b0, pdr = 1'b0;
  logic [2:0] ndr = '0;
  logic [2:0] sh;
  logic       hv;
  logic [1:0] hidx;
  logic [7:0] hcnt;

  logic       sof8 = 1'b0, nr8 = 1'b0, pdr8 = 1'b0;
  logic [7:0] ndr8 = '0;
  logic [7:0] sh8;
  logic       hv8;
  logic [2:0] hidx8;
  logic [1:0] hcnt8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  number_hit_detector #(
    .NUMBERS (3),
    .COUNT_W (8)
  ) u_dut (
    .clk              (clk),
    .resetN           (resetN),
    .start_of_frame_i (sof),
    .new_round_i      (nr),
    .player_dr_i      (pdr),
    .numbers_dr_i     (ndr),
    .single_hit_o     (sh),
    .hit_valid_o      (hv),
    .hit_index_o      (hidx),
    .hit_count_o      (hcnt)
  );

  number_hit_detector #(
    .NUMBERS (8),
    .COUNT_W (2)
  ) u_dut8 (
    .clk              (clk),
    .resetN           (resetN),
    .start_of_frame_i (sof8),
    .new_round_i      (nr8),
    .player_dr_i      (pdr8),
    .numbers_dr_i     (ndr8),
    .single_hit_o     (sh8),
    .hit_valid_o      (hv8),
    .hit_index_o      (hidx8),
    .hit_count_o      (hcnt8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] e_sh, input logic e_hv,
                           input logic [1:0] e_idx, input logic [7:0] e_cnt);
    check({tag, ".singleHit"}, 32'(sh), 32'(e_sh));
    check({tag, ".hitValid"}, 32'(hv), 32'(e_hv));
    check({tag, ".hitIndex"}, 32'(hidx), 32'(e_idx));
    check({tag, ".hitCount"}, 32'(hcnt), 32'(e_cnt));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic overlap(input logic [2:0] mask, input int cycles);
    pdr = 1'b1;
    ndr = mask;
    step(cycles);
    pdr = 1'b0;
    ndr = '0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    step(1);
    sof = 1'b0;
  endtask

  task automatic pulse_nr();
    nr = 1'b1;
    step(1);
    nr = 1'b0;
  endtask

  initial begin
    // Reset held: outputs at reset values.
    #12;
    check_out("reset", 3'b000, 1'b0, 2'd0, 8'd0);
    resetN = 1'b1;
    step(1);

    // Two idle frames.
    for (int i = 0; i < 16; i++) begin
      sof = (i == 3 || i == 11);
      step(1);
      check_out("idle", 3'b000, 1'b0, 2'd0, 8'd0);
    end
    sof = 1'b0;

    // Single hit on number 1; pulse appears two edges after the startOfFrame edge.
    step(3);
    overlap(3'b010, 5);
    step(2);
    pulse_sof();
    check_out("single.pre", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    check_out("single.hit", 3'b010, 1'b1, 2'd1, 8'd1);
    step(1);
    check_out("single.after", 3'b000, 1'b0, 2'd0, 8'd1);

    // Same overlap next frame: already consumed.
    overlap(3'b010, 5);
    pulse_sof();
    step(1);
    check_out("consumed.f1", 3'b000, 1'b0, 2'd0, 8'd1);
    step(1);
    check_out("consumed.f2", 3'b000, 1'b0, 2'd0, 8'd1);

    // newRound re-arms number 1 and clears the count.
    pulse_nr();
    check_out("nr.clear", 3'b000, 1'b0, 2'd0, 8'd0);
    overlap(3'b010, 3);
    pulse_sof();
    step(1);
    check_out("rearm.hit", 3'b010, 1'b1, 2'd1, 8'd1);

    // newRound coincident with startOfFrame while acc holds number 0.
    pulse_nr();
    overlap(3'b001, 3);
    sof = 1'b1;
    nr  = 1'b1;
    step(1);
    sof = 1'b0;
    nr  = 1'b0;
    check_out("nr_sof.c0", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    check_out("nr_sof.c1", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    check_out("nr_sof.c2", 3'b000, 1'b0, 2'd0, 8'd0);

    // Numbers drawn with no player: nothing.
    ndr = 3'b111;
    step(8);
    ndr = '0;
    pulse_sof();
    step(1);
    check_out("noplayer.c1", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    check_out("noplayer.c2", 3'b000, 1'b0, 2'd0, 8'd0);

    // Numbers 0 and 2 in one frame: back-to-back pulses, ascending.
    overlap(3'b001, 2);
    step(2);
    overlap(3'b100, 2);
    pulse_sof();
    step(1);
    check_out("multi.p0", 3'b001, 1'b1, 2'd0, 8'd1);
    step(1);
    check_out("multi.p2", 3'b100, 1'b1, 2'd2, 8'd2);
    step(1);
    check_out("multi.end", 3'b000, 1'b0, 2'd0, 8'd2);

    // newRound during REPORT drops the pulse due that cycle.
    pulse_nr();
    overlap(3'b011, 3);
    pulse_sof();
    nr = 1'b1;
    step(1);
    nr = 1'b0;
    check_out("nr_report.drop", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    check_out("nr_report.next", 3'b000, 1'b0, 2'd0, 8'd0);

    // startOfFrame during REPORT merges number 2 behind pending 0 and 1.
    pulse_nr();
    overlap(3'b011, 3);
    pulse_sof();
    pdr = 1'b1;
    ndr = 3'b100;
    sof = 1'b1;
    step(1);
    sof = 1'b0;
    pdr = 1'b0;
    ndr = '0;
    check_out("merge.p0", 3'b001, 1'b1, 2'd0, 8'd1);
    step(1);
    check_out("merge.p1", 3'b010, 1'b1, 2'd1, 8'd2);
    step(1);
    check_out("merge.p2", 3'b100, 1'b1, 2'd2, 8'd3);
    step(1);
    check_out("merge.end", 3'b000, 1'b0, 2'd0, 8'd3);
    step(1);
    check_out("merge.quiet", 3'b000, 1'b0, 2'd0, 8'd3);

    // Saturating count on the 8-number, 2-bit-count instance.
    for (int k = 0; k < 5; k++) begin
      pdr8 = 1'b1;
      ndr8 = 8'(1 << k);
      step(2);
      pdr8 = 1'b0;
      ndr8 = '0;
      sof8 = 1'b1;
      step(1);
      sof8 = 1'b0;
      step(1);
      check($sformatf("sat%0d.singleHit", k), 32'(sh8), 32'(1 << k));
      check($sformatf("sat%0d.hitIndex", k), 32'(hidx8), 32'(k));
      check($sformatf("sat%0d.hitCount", k), 32'(hcnt8), (k < 3) ? 32'(k + 1) : 32'd3);
      step(1);
      check($sformatf("sat%0d.gap", k), 32'(hv8), 32'd0);
    end

    // Asynchronous reset in the middle of a multi-number report.
    pulse_nr();
    overlap(3'b111, 2);
    pulse_sof();
    step(1);
    check_out("areset.first", 3'b001, 1'b1, 2'd0, 8'd1);
    #2;
    resetN = 1'b0;
    #1;
    check_out("areset.now", 3'b000, 1'b0, 2'd0, 8'd0);
    step(1);
    #3;
    resetN = 1'b1;
    step(2);
    check_out("areset.lost", 3'b000, 1'b0, 2'd0, 8'd0);
    check("areset.count8", 32'(hcnt8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/number_hit_detector.md
Name: number_hit_detector

Overview:
- Producer side of the per-number hit interface consumed by the number display array.
- Watches the player sprite draw request against each number's draw request during the frame, accumulating pixel-level overlaps.
- At frame boundary, converts accumulated overlaps into one-cycle one-hot singleHit pulses, one number per cycle, lowest index first.
- Each number reports at most once per round; the block also keeps a saturating hit count for the score logic.

Parameters:
- NUMBERS, 3, number of number objects; width of numbersDR / singleHit.
- IDX_W, $clog2(NUMBERS) (min 1), width of hitIndex.
- COUNT_W, 8, width of hitCount.

Ports:
- clk  in  1  system clock.
- resetN  in  1  async active-low reset.
- startOfFrame  in  1  one-cycle pulse at frame start, from the VGA controller.
- newRound  in  1  one-cycle pulse; re-arms all numbers, to match the display's reset of its show flags.
- playerDR  in  1  player sprite drawing request for the current pixel.
- numbersDR  in  NUMBERS  per-number drawing requests for the current pixel.
- singleHit  out  NUMBERS  one-hot hit pulse to the number display array.
- hitValid  out  1  high in the same cycle singleHit is nonzero.
- hitIndex  out  IDX_W  index of the asserted singleHit bit; 0 when hitValid=0.
- hitCount  out  COUNT_W  total hits this round, saturating.

Behaviour:
- Reset values (async, resetN=0):
  - singleHit=0, hitValid=0, hitIndex=0, hitCount=0.
  - Internal acc=0, pending=0, consumed=0, state=ACCUM.
- Overlap term, every cycle: ovl = numbersDR & {NUMBERS{playerDR}} & ~consumed & ~pending.
- State ACCUM:
  - acc <= acc | ovl each cycle.
  - On startOfFrame: pending <= acc | ovl; acc <= 0.
    - Go to REPORT if (acc|ovl) != 0, else stay in ACCUM.
- State REPORT:
  - Each cycle: b = lowest set bit of pending.
  - Registered outputs, next cycle: singleHit = one-hot(b), hitValid=1, hitIndex=b. Latency is 1 cycle from pending to output.
  - pending[b] <= 0; consumed[b] <= 1; hitCount <= hitCount+1, saturating at 2^COUNT_W-1.
  - Accumulation continues in parallel: acc <= acc | ovl.
  - When the last pending bit is cleared, go to ACCUM.
  - startOfFrame while in REPORT: pending <= (pending minus the bit cleared this cycle) | acc | ovl; acc <= 0; stay in REPORT.
- Output rules:
  - singleHit and hitValid are single-cycle pulses.
  - Outputs are 0 in every cycle with no report.
  - At most one singleHit bit is high in any cycle.
- consumed bits:
  - Never report again until newRound.
  - Pixels from a consumed number never re-enter acc.
- newRound (synchronous):
  - Clears acc, pending, consumed and hitCount; state <= ACCUM.
  - Outputs are 0 in the following cycle.
  - Takes priority over startOfFrame and any report in the same cycle; a pulse that would have issued that cycle is dropped.
- Asynchronous reset mid-REPORT: all pending reports are lost; outputs return to reset values immediately.
- Multiple overlapping numbers in one frame: all are reported, ascending index, on consecutive cycles after the startOfFrame, with no gaps.

Decomposition:
- Shared package holds:
  - The NUMBERS default, shared with the display array.
  - COUNT_W.
  - The state enum typedef {ACCUM, REPORT}.
- One natural sub-module: lsb_priority_encoder. It is parameterised by NUMBERS, is combinational, and outputs index, one-hot and any flag. It is reused by other collision blocks.

Test Plan:
- Reset and idle: hold resetN=0, then release; no stimulus for 2 frames -> singleHit=0, hitValid=0, hitIndex=0, hitCount=0 throughout.
- Single hit: NUMBERS=3; playerDR=1 with numbersDR=3'b010 for 5 cycles mid-frame, then startOfFrame -> one pulse singleHit=3'b010, hitIndex=1, hitCount=1. Repeating the same overlap next frame -> no pulse, hitCount stays 1.
- Multiple hits: overlaps on numbers 0 and 2 in one frame -> pulses 3'b001 then 3'b100 on two consecutive cycles after startOfFrame, with hitIndex 0 then 2; hitCount=2.
- No player: numbersDR=3'b111 with playerDR=0 for a whole frame -> no pulses.
- newRound re-arm: after number 1 is consumed, pulse newRound, then overlap number 1 again -> pulse 3'b010, hitCount=1 (not 2). newRound coincident with startOfFrame and acc != 0 -> no pulse.
- Saturation and startOfFrame during REPORT:
  - With COUNT_W=2, five single hits across rounds without newRound (NUMBERS=8 config) -> hitCount saturates at 3.
  - startOfFrame during REPORT merges new overlaps, with no lost or duplicate pulses.
